// File: rtl/time_sync_ctrl_if.sv
// Fetcher/clock-core link for time_sync_ctrl: the controller is the master side.
// All signals are single-cycle strobes: fetch_en starts one fetch; fetch_done (with fetch_err) ends it
// and is only honoured while a fetch is outstanding; set_pulse qualifies set_value for one cycle.
interface time_sync_ctrl_if #(
  parameter int TS_W  = 32,
  parameter int OUT_W = 64
);
  logic             fetch_en;
  logic             fetch_done;
  logic             fetch_err;
  logic [TS_W-1:0]  fetch_value;
  logic             set_pulse;
  logic [OUT_W-1:0] set_value;

  modport master (
    output fetch_en, set_pulse, set_value,
    input  fetch_done, fetch_err, fetch_value
  );

  modport slave (
    input  fetch_en, set_pulse, set_value,
    output fetch_done, fetch_err, fetch_value
  );
endinterface

// File: rtl/time_sync_ctrl.sv
// Time fetch sequencer: button/auto trigger, timeout with bounded retries and backoff,
// cancel on a second key press, and a one-cycle set strobe into the clock core.
module time_sync_ctrl #(
  parameter int TS_W        = 32,
  parameter int OUT_W       = 64,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRY   = 2,
  parameter int BACKOFF_CYC = 1_000_000,
  parameter int AUTO_PERIOD = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_btn,
  time_sync_ctrl_if.master                 bus,
  output logic                             busy,
  output logic [1:0]                       status,
  output logic [$clog2(MAX_RETRY+2)-1:0]   attempt,
  output logic [2:0]                       o_state
);
  localparam int ATT_W  = $clog2(MAX_RETRY + 2);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BO_W   = $clog2(BACKOFF_CYC + 1);
  localparam int AUTO_W = (AUTO_PERIOD > 0) ? $clog2(AUTO_PERIOD + 1) : 1;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_OK   = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;
  localparam logic [1:0] ST_CAN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_SET     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic               r_btn_prev;
  logic               r_fetch_en, w_fetch_en;
  logic               r_set_pulse, w_set_pulse;
  logic [OUT_W-1:0]   r_set_value, w_set_value;
  logic               r_busy;
  logic [1:0]         r_status, w_status;
  logic [ATT_W-1:0]   r_attempt, w_attempt;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_cnt;
  logic [BO_W-1:0]    r_bo_cnt, w_bo_cnt;
  logic [AUTO_W-1:0]  r_auto_cnt, w_auto_cnt;
  logic               w_btn_rise;
  logic               w_auto_hit;

  assign w_btn_rise = req_btn & ~r_btn_prev;
  assign w_auto_hit = (AUTO_PERIOD != 0) && (r_auto_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_btn_prev  <= 1'b1;
      r_fetch_en  <= 1'b0;
      r_set_pulse <= 1'b0;
      r_set_value <= '0;
      r_busy      <= 1'b0;
      r_status    <= ST_NONE;
      r_attempt   <= '0;
      r_wait_cnt  <= '0;
      r_bo_cnt    <= '0;
      r_auto_cnt  <= AUTO_W'(AUTO_PERIOD);
    end else begin
      r_state     <= w_state;
      r_btn_prev  <= req_btn;
      r_fetch_en  <= w_fetch_en;
      r_set_pulse <= w_set_pulse;
      r_set_value <= w_set_value;
      r_busy      <= (w_state != S_IDLE);
      r_status    <= w_status;
      r_attempt   <= w_attempt;
      r_wait_cnt  <= w_wait_cnt;
      r_bo_cnt    <= w_bo_cnt;
      r_auto_cnt  <= w_auto_cnt;
    end
  end

  // Strobes are computed from the transition so they line up with the state they belong to.
  always_comb begin
    w_state     = r_state;
    w_fetch_en  = 1'b0;
    w_set_pulse = 1'b0;
    w_set_value = r_set_value;
    w_status    = r_status;
    w_attempt   = r_attempt;
    w_wait_cnt  = r_wait_cnt;
    w_bo_cnt    = r_bo_cnt;
    w_auto_cnt  = r_auto_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_auto_cnt != '0) w_auto_cnt = r_auto_cnt - AUTO_W'(1);
        if (w_btn_rise || w_auto_hit) begin
          w_state    = S_REQ;
          w_attempt  = ATT_W'(1);
          w_fetch_en = 1'b1;
        end
      end
      S_REQ: begin
        w_wait_cnt = WAIT_W'(TIMEOUT_CYC);
        w_state    = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt != '0) w_wait_cnt = r_wait_cnt - WAIT_W'(1);
        if (bus.fetch_done && !bus.fetch_err) begin
          w_set_value = OUT_W'(bus.fetch_value);
          w_set_pulse = 1'b1;
          w_state     = S_SET;
        end else if (w_btn_rise) begin
          w_status = ST_CAN;
          w_state  = S_DONE;
        end else if (bus.fetch_err || (r_wait_cnt == WAIT_W'(1))) begin
          if (r_attempt <= ATT_W'(MAX_RETRY)) begin
            w_bo_cnt = BO_W'(BACKOFF_CYC);
            w_state  = S_BACKOFF;
          end else begin
            w_status = ST_FAIL;
            w_state  = S_DONE;
          end
        end
      end
      S_BACKOFF: begin
        if (r_bo_cnt != '0) w_bo_cnt = r_bo_cnt - BO_W'(1);
        if (w_btn_rise) begin
          w_status = ST_CAN;
          w_state  = S_DONE;
        end else if (r_bo_cnt == BO_W'(1)) begin
          w_attempt  = r_attempt + ATT_W'(1);
          w_fetch_en = 1'b1;
          w_state    = S_REQ;
        end
      end
      S_SET: begin
        w_status = ST_OK;
        w_state  = S_DONE;
      end
      S_DONE: begin
        w_auto_cnt = AUTO_W'(AUTO_PERIOD);
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.fetch_en  = r_fetch_en;
  assign bus.set_pulse = r_set_pulse;
  assign bus.set_value = r_set_value;
  assign busy          = r_busy;
  assign status        = r_status;
  assign attempt       = r_attempt;
  assign o_state       = r_state;
endmodule

// File: tb/tb_time_sync_ctrl.sv
// Directed bench for time_sync_ctrl: dut0 runs the button-driven scenarios, dut1 free-runs
// with auto-resync; per-request results are checked against an expected queue.
module tb_time_sync_ctrl;
  localparam int TS_W  = 32;
  localparam int OUT_W = 64;
  localparam int TO    = 100;
  localparam int MR    = 2;
  localparam int BO    = 10;
  localparam int AP    = 50;
  localparam int SB_W  = 2 + 2 + 4 + 4 + OUT_W;

  logic clk = 1'b0;
  logic rst, rst1, btn, btn1;
  always #5 clk = ~clk;

  time_sync_ctrl_if #(.TS_W(TS_W), .OUT_W(OUT_W)) bus0 ();
  time_sync_ctrl_if #(.TS_W(TS_W), .OUT_W(OUT_W)) bus1 ();

  logic       busy0, busy1;
  logic [1:0] st0, st1, att0, att1;
  logic [2:0] dbg0, dbg1;

  time_sync_ctrl #(.TS_W(TS_W), .OUT_W(OUT_W), .TIMEOUT_CYC(TO), .MAX_RETRY(MR),
                   .BACKOFF_CYC(BO), .AUTO_PERIOD(0)) dut0 (
    .clk(clk), .reset(rst), .req_btn(btn), .bus(bus0),
    .busy(busy0), .status(st0), .attempt(att0), .o_state(dbg0));

  time_sync_ctrl #(.TS_W(TS_W), .OUT_W(OUT_W), .TIMEOUT_CYC(TO), .MAX_RETRY(MR),
                   .BACKOFF_CYC(BO), .AUTO_PERIOD(AP)) dut1 (
    .clk(clk), .reset(rst1), .req_btn(btn1), .bus(bus1),
    .busy(busy1), .status(st1), .attempt(att1), .o_state(dbg1));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [SB_W-1:0] pack(input logic [1:0] s, input logic [1:0] a,
                                           input logic [3:0] nf, input logic [3:0] ns,
                                           input logic [63:0] v);
    return {s, a, nf, ns, v};
  endfunction

  // dut0 monitor: tallies strobes per request and compares when busy drops
  int   n_fe0 = 0;
  int   n_sp0 = 0;
  int   stray0 = 0;
  int   sp_cyc = -1;
  int   fe_cyc[$];
  logic prev_busy0 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy0 = 1'b0;
    end else begin
      if (busy0 && !prev_busy0) begin
        n_fe0 = 0;
        n_sp0 = 0;
        fe_cyc.delete();
      end
      if (bus0.fetch_en) begin
        if (busy0) begin n_fe0++; fe_cyc.push_back(cyc); end
        else stray0++;
      end
      if (bus0.set_pulse) begin
        if (busy0) begin n_sp0++; sp_cyc = cyc; end
        else stray0++;
      end
      if (!busy0 && prev_busy0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: request ended with status %0d, no expectation queued", st0);
        end else begin
          check("sb_result",
                128'({st0, att0, n_fe0[3:0], n_sp0[3:0], bus0.set_value}),
                128'(exp_q.pop_front()));
        end
      end
      prev_busy0 = busy0;
    end
  end

  // dut1 monitor: gap from first IDLE cycle to each auto fetch_en
  int   idle_start1 = 0;
  int   gaps1[$];
  logic prev_busy1 = 1'b1;
  always @(negedge clk) begin
    if (rst1) begin
      prev_busy1 = 1'b1;
    end else begin
      if (!busy1 && prev_busy1) idle_start1 = cyc;
      if (bus1.fetch_en) gaps1.push_back(cyc - idle_start1);
      prev_busy1 = busy1;
    end
  end

  // dut1 fetcher model: answers every request five cycles later
  initial begin
    bus1.fetch_done  = 1'b0;
    bus1.fetch_err   = 1'b0;
    bus1.fetch_value = '0;
    forever begin
      tick(1);
      if (bus1.fetch_en) begin
        tick(4);
        bus1.fetch_done  = 1'b1;
        bus1.fetch_value = 32'hA5A5_0001;
        tick(1);
        bus1.fetch_done  = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy0 && n < max) begin tick(1); n++; end
    if (busy0) check({name, "_timeout"}, 128'(busy0), 128'(0));
  endtask

  task automatic wait_fe0(input int max, input string name);
    int n = 0;
    do begin tick(1); n++; end while (!bus0.fetch_en && n < max);
    if (!bus0.fetch_en) check({name, "_no_fetch_en"}, 128'(bus0.fetch_en), 128'(1));
  endtask

  int c0;
  int d1, d2;

  initial begin
    rst = 1'b1; rst1 = 1'b1; btn = 1'b0; btn1 = 1'b0;
    bus0.fetch_done = 1'b0; bus0.fetch_err = 1'b0; bus0.fetch_value = '0;
    tick(3);
    check("rst_busy",      128'(busy0),          128'(0));
    check("rst_status",    128'(st0),            128'(0));
    check("rst_attempt",   128'(att0),           128'(0));
    check("rst_set_value", 128'(bus0.set_value), 128'(0));
    check("rst_fetch_en",  128'(bus0.fetch_en),  128'(0));
    rst = 1'b0; rst1 = 1'b0;
    tick(5);

    // basic success: key at c0, fetch_done at c0+15
    exp_q.push_back(pack(2'd1, 2'd1, 4'd1, 4'd1, 64'h0000_0000_66E1_A2B0));
    c0 = cyc;
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(12);
    bus0.fetch_done = 1'b1; bus0.fetch_value = 32'h66E1_A2B0;
    tick(1);
    bus0.fetch_done = 1'b0;
    tick(2);
    check("t1_busy_low", 128'(busy0), 128'(0));
    check("t1_fetch_en_cycle", 128'((fe_cyc.size() == 1) ? fe_cyc[0] - c0 : -1), 128'(1));
    check("t1_set_pulse_cycle", 128'(sp_cyc - c0), 128'(16));
    tick(2);

    // no response: three attempts spaced TO+BO+1 apart, then failure
    exp_q.push_back(pack(2'd2, 2'd3, 4'd3, 4'd0, 64'h0000_0000_66E1_A2B0));
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    wait_idle(400, "t2");
    tick(1);
    d1 = (fe_cyc.size() >= 2) ? fe_cyc[1] - fe_cyc[0] : -1;
    d2 = (fe_cyc.size() >= 3) ? fe_cyc[2] - fe_cyc[1] : -1;
    check("t2_fetch_count", 128'(fe_cyc.size()), 128'(3));
    check("t2_spacing_1", 128'(d1), 128'(111));
    check("t2_spacing_2", 128'(d2), 128'(111));
    tick(2);

    // error on first attempt, success on the retry
    exp_q.push_back(pack(2'd1, 2'd2, 4'd2, 4'd1, 64'h0000_0000_1234_5678));
    btn = 1'b1;
    wait_fe0(10, "t3a");
    btn = 1'b0;
    tick(5);
    bus0.fetch_err = 1'b1;
    tick(1);
    bus0.fetch_err = 1'b0;
    wait_fe0(50, "t3b");
    tick(3);
    bus0.fetch_done = 1'b1; bus0.fetch_value = 32'h1234_5678;
    tick(1);
    bus0.fetch_done = 1'b0;
    wait_idle(20, "t3");
    tick(2);

    // cancel 30 cycles into WAIT, then a stray fetch_done must be ignored
    exp_q.push_back(pack(2'd3, 2'd1, 4'd1, 4'd0, 64'h0000_0000_1234_5678));
    btn = 1'b1;
    wait_fe0(10, "t4");
    btn = 1'b0;
    tick(30);
    btn = 1'b1;
    tick(2);
    check("t4_cancel_busy", 128'(busy0), 128'(0));
    tick(2);
    btn = 1'b0;
    bus0.fetch_done = 1'b1; bus0.fetch_value = 32'hDEAD_BEEF;
    tick(1);
    bus0.fetch_done = 1'b0;
    tick(3);
    check("t4_value_kept", 128'(bus0.set_value), 128'(64'h0000_0000_1234_5678));
    check("t4_no_stray", 128'(stray0), 128'(0));

    // fetch_done and a cancel press in the same cycle: success wins
    exp_q.push_back(pack(2'd1, 2'd1, 4'd1, 4'd1, 64'h0000_0000_0BAD_F00D));
    btn = 1'b1;
    wait_fe0(10, "t5");
    btn = 1'b0;
    tick(5);
    bus0.fetch_done = 1'b1; bus0.fetch_value = 32'h0BAD_F00D; btn = 1'b1;
    tick(1);
    bus0.fetch_done = 1'b0;
    wait_idle(20, "t5");
    btn = 1'b0;
    tick(2);

    // async reset in WAIT, key held across release must not retrigger
    btn = 1'b1;
    wait_fe0(10, "t6");
    tick(10);
    #2;
    rst = 1'b1;
    bus0.fetch_done = 1'b1; bus0.fetch_value = 32'hFFFF_FFFF;
    #1;
    check("t6_rst_busy",      128'(busy0),          128'(0));
    check("t6_rst_status",    128'(st0),            128'(0));
    check("t6_rst_attempt",   128'(att0),           128'(0));
    check("t6_rst_set_value", 128'(bus0.set_value), 128'(0));
    check("t6_rst_set_pulse", 128'(bus0.set_pulse), 128'(0));
    check("t6_rst_fetch_en",  128'(bus0.fetch_en),  128'(0));
    tick(3);
    bus0.fetch_done = 1'b0;
    rst = 1'b0;
    tick(20);
    check("t6_held_key_idle", 128'(busy0), 128'(0));
    check("t6_value_after",   128'(bus0.set_value), 128'(0));
    check("t6_no_stray",      128'(stray0), 128'(0));
    btn = 1'b0;
    tick(2);

    // auto-resync on dut1: trigger cycle counted, so the gap is AP+1
    check("auto_count", 128'(gaps1.size() >= 2), 128'(1));
    check("auto_gap_reset", 128'((gaps1.size() >= 1) ? gaps1[0] : -1), 128'(AP + 1));
    check("auto_gap_done",  128'((gaps1.size() >= 2) ? gaps1[1] : -1), 128'(AP + 1));
    check("auto_status", 128'(st1), 128'(1));
    check("auto_value", 128'(bus1.set_value), 128'(64'h0000_0000_A5A5_0001));

    check("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/time_sync_ctrl.md
Name: time_sync_ctrl

Overview:
- Parametrised controller that requests a timestamp from the network time fetcher (UART side) and hands it to the clock core as a one-cycle set strobe.
- Generalises the top-level fetch/cancel sequencer with configurable widths, response timeout, bounded retries with backoff, optional periodic auto-resync and a last-result status code.
- Sits between the keypad key-state outputs, the time fetcher and the clock_interface set port.

Parameters:
- TS_W, 32, width of the fetched timestamp.
- OUT_W, 64, width of set_value; must be >= TS_W; the timestamp is zero-extended.
- TIMEOUT_CYC, 50_000_000, cycles to wait for fetch_done per attempt; must be >= 1.
- MAX_RETRY, 2, extra attempts after the first failure; 0 means single attempt.
- BACKOFF_CYC, 1_000_000, idle cycles between a failed attempt and the retry; must be >= 1.
- AUTO_PERIOD, 0, cycles spent in IDLE before an automatic request; 0 disables.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_btn  in  1  debounced key level; rising edge starts a request, or cancels one in flight
- fetch_en  out  1  one-cycle start pulse to the fetcher
- fetch_done  in  1  fetcher completion strobe
- fetch_err  in  1  fetcher error strobe; only valid while fetch_done or alone
- fetch_value  in  TS_W  timestamp; valid when fetch_done=1
- set_pulse  out  1  one-cycle "load time" strobe to the clock core
- set_value  out  OUT_W  zero-extended timestamp; holds last successful value
- busy  out  1  high in any state other than IDLE
- status  out  2  last result: 0 none, 1 ok, 2 failed, 3 cancelled
- attempt  out  clog2(MAX_RETRY+2)  attempt number of the current/last request, starting at 1

Behaviour:
- Reset (async, active-high) clears state to IDLE, fetch_en=0, set_pulse=0, set_value=0, busy=0, status=0, attempt=0, wait/backoff counters=0, auto counter=AUTO_PERIOD, btn_prev=1. btn_prev=1 means a key already held at reset release does not trigger.
- Edge detect: btn_rise = req_btn & ~btn_prev; btn_prev is registered every cycle.
- All outputs are registered.
- IDLE:
  - On btn_rise, or on auto_hit (AUTO_PERIOD!=0 and auto counter==0), go to REQ with attempt=1.
  - A simultaneous btn_rise and auto_hit gives a single request.
  - The auto counter decrements by 1 per IDLE cycle and saturates at 0.
- REQ:
  - fetch_en=1 for exactly this one cycle; wait counter loads TIMEOUT_CYC; go to WAIT.
  - fetch_en therefore rises the cycle after the trigger is sampled.
- WAIT: the wait counter decrements each cycle. Priority, highest first:
  - (a) fetch_done & ~fetch_err: set_value<={0,fetch_value}, go to SET.
  - (b) btn_rise: status=3, go to DONE.
  - (c) fetch_err, or wait counter==1 (timeout after TIMEOUT_CYC WAIT cycles): if attempt<=MAX_RETRY, load backoff counter BACKOFF_CYC and go to BACKOFF; otherwise status=2, go to DONE.
- BACKOFF:
  - Counts down; at 1, attempt++ and go to REQ.
  - btn_rise here cancels: status=3, go to DONE.
  - fetch_done in BACKOFF is ignored.
- SET: set_pulse=1 for this one cycle, status=1, go to DONE. set_pulse follows the accepted fetch_done by exactly one cycle.
- DONE: one cycle; reload the auto counter with AUTO_PERIOD; go to IDLE. A btn_rise in DONE is consumed and does not re-trigger.
- fetch_done/fetch_err outside WAIT are ignored and have no side effects.
- set_value changes only on a successful fetch. It does not change on fail or cancel.
- Reset mid-operation aborts immediately. No set_pulse or fetch_en is issued after reset asserts.

Test Plan:
- TIMEOUT_CYC=100, MAX_RETRY=2, BACKOFF_CYC=10, AUTO_PERIOD=0. req_btn 0→1 at cycle 5, fetch_done with fetch_value=0x66E1_A2B0 at cycle 20 -> fetch_en high cycle 6 only; set_pulse high cycle 21 only; set_value=0x0000_0000_66E1_A2B0; status=1; attempt=1; busy low by cycle 23.
- Same parameters, no fetch_done -> three fetch_en pulses spaced 100+10+1 cycles apart; status=2; attempt=3; set_pulse never asserts; set_value unchanged.
- fetch_err on attempt 1, success on attempt 2 -> exactly 2 fetch_en pulses, set_pulse once, status=1, attempt=2.
- Second req_btn rising edge 30 cycles into WAIT -> status=3, busy drops within 2 cycles; a later fetch_done is ignored; set_value unchanged.
- fetch_done and btn_rise in the same WAIT cycle -> success wins: set_pulse asserts, status=1.
- AUTO_PERIOD=50, button idle -> fetch_en after 50 IDLE cycles; after success, next fetch_en 50 IDLE cycles after returning to IDLE. Reset asserted mid-WAIT clears all outputs asynchronously, with no set_pulse.
